// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
package uart_pkg;

    localparam int UART_DATA_BITS   = 8;
    localparam int UART_DEFAULT_DIV = 217;  // 25 MHz / 115200

    // IDLE: line high, waiting for a byte | START/DATA/PARITY/STOP: frame fields on txd
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, no fall-through; dout shows the head entry while not empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage is not reset; clearing the pointers is enough to flush it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_buffered_tx.sv
// Buffered UART transmitter: byte FIFO feeding a frame serialiser with runtime divisor,
// optional parity and one or two stop bits. Frame settings are captured at each frame start.
module uart_buffered_tx
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int MIN_DIV    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_WIDTH-1:0]          baud_div,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          two_stop,
    input  logic [7:0]                    data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          busy_o,
    output logic                          txd_o
);

    localparam int         CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [7:0]           fifo_dout;
    logic [CW-1:0]        fifo_count;
    logic [CW-1:0]        count_d;

    uart_tx_state_t       state_q, state_d;
    logic [DIV_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] div_eff;
    logic [2:0]           idx_q, idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           byte_q, byte_d;
    logic                 par_en_q, par_en_d;
    logic                 par_odd_q, par_odd_d;
    logic                 two_stop_q, two_stop_d;
    logic                 txd_q, txd_d;
    logic                 busy_q, busy_d;
    logic                 bit_end;
    logic                 start_frame;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (data_i),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign ready_o      = !fifo_full;
    assign fifo_push    = valid_i && ready_o;
    assign fifo_count_o = fifo_count;
    assign busy_o       = busy_q;
    assign txd_o        = txd_q;

    assign div_eff = (baud_div < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : baud_div;
    assign count_d = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    assign bit_end = (bit_cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        div_d       = div_q;
        idx_d       = idx_q;
        stop_idx_d  = stop_idx_q;
        shift_d     = shift_q;
        byte_d      = byte_q;
        par_en_d    = par_en_q;
        par_odd_d   = par_odd_q;
        two_stop_d  = two_stop_q;
        fifo_pop    = 1'b0;
        start_frame = 1'b0;

        case (state_q)
            IDLE: begin
                start_frame = !fifo_empty;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == LAST_BIT) begin
                        state_d    = par_en_q ? PARITY : STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d    = STOP;
                    stop_idx_d = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (two_stop_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else if (!fifo_empty) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_q != IDLE) begin
            bit_cnt_d = bit_end ? (div_q - DIV_WIDTH'(1)) : (bit_cnt_q - DIV_WIDTH'(1));
        end

        // Frame start from IDLE or straight out of the last stop bit (no idle gap).
        if (start_frame) begin
            fifo_pop   = 1'b1;
            state_d    = START;
            shift_d    = fifo_dout;
            byte_d     = fifo_dout;
            div_d      = div_eff;
            par_en_d   = parity_en;
            par_odd_d  = parity_odd;
            two_stop_d = two_stop;
            bit_cnt_d  = div_eff - DIV_WIDTH'(1);
            stop_idx_d = 1'b0;
        end

        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            PARITY:  txd_d = (^byte_d) ^ par_odd_d;
            default: txd_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            div_q      <= DIV_WIDTH'(MIN_DIV);
            idx_q      <= 3'd0;
            stop_idx_q <= 1'b0;
            shift_q    <= 8'h00;
            byte_q     <= 8'h00;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            byte_q     <= byte_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            two_stop_q <= two_stop_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_buffered_tx.sv
// Directed self-checking bench for uart_buffered_tx; line sampled on the falling clock edge.
module tb_uart_buffered_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] baud_div;
    logic        parity_en;
    logic        parity_odd;
    logic        two_stop;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        ready_o;
    logic [4:0]  fifo_count_o;
    logic        busy_o;
    logic        txd_o;

    int checks = 0;
    int errors = 0;

    uart_buffered_tx #(
        .FIFO_DEPTH (16),
        .DIV_WIDTH  (16),
        .MIN_DIV    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .baud_div     (baud_div),
        .parity_en    (parity_en),
        .parity_odd   (parity_odd),
        .two_stop     (two_stop),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .fifo_count_o (fifo_count_o),
        .busy_o       (busy_o),
        .txd_o        (txd_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller is at a falling edge; the byte is offered across the next rising edge.
    task automatic push_byte(input logic [7:0] b);
        data_i  = b;
        valid_i = 1'b1;
        @(negedge clk);
    endtask

    // Checks every cycle of one frame. search=1 hunts for the start bit; search=0
    // demands the start bit on the very next cycle. Returns on the last stop cycle.
    task automatic check_frame(input logic [7:0] b, input int div, input logic pe,
                               input logic po, input logic ts, input bit search,
                               input int exp_cnt);
        logic [11:0] bits;
        int          nbits;
        int          n;
        logic        obs;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
        nbits = 9;
        if (pe) begin
            bits[nbits] = (^b) ^ po;
            nbits++;
        end
        bits[nbits] = 1'b1;
        nbits++;
        if (ts) begin
            bits[nbits] = 1'b1;
            nbits++;
        end
        n = 0;
        @(negedge clk);
        if (search) begin
            while (txd_o !== 1'b0 && n < 20000) begin
                @(negedge clk);
                n++;
            end
        end
        if (exp_cnt >= 0) chk($sformatf("start_count_%02h", b), 32'(fifo_count_o), exp_cnt);
        for (int k = 0; k < nbits; k++) begin
            obs = bits[k];
            for (int c = 0; c < div; c++) begin
                if (!(k == 0 && c == 0)) @(negedge clk);
                if (txd_o !== bits[k]) obs = txd_o;
            end
            chk($sformatf("frame_%02h_bit%0d", b, k), 32'(obs), 32'(bits[k]));
        end
    endtask

    initial begin
        logic [7:0] fb [18];
        logic [7:0] b0;
        int         n;
        logic       seen;

        rst        = 1'b1;
        baud_div   = 16'd4;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        two_stop   = 1'b0;
        data_i     = 8'h00;
        valid_i    = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_txd", 32'(txd_o), 32'd1);
        chk("reset_ready", 32'(ready_o), 32'd1);
        chk("reset_count", 32'(fifo_count_o), 32'd0);
        chk("reset_busy", 32'(busy_o), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic 8N1, div 4, byte 0x55
        push_byte(8'h55);
        valid_i = 1'b0;
        chk("basic_txd_before_start", 32'(txd_o), 32'd1);
        chk("basic_count", 32'(fifo_count_o), 32'd1);
        chk("basic_busy", 32'(busy_o), 32'd1);
        check_frame(8'h55, 4, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk("basic_busy_last_stop", 32'(busy_o), 32'd1);
        @(negedge clk);
        chk("basic_busy_fall", 32'(busy_o), 32'd0);
        chk("basic_txd_idle", 32'(txd_o), 32'd1);
        repeat (3) @(negedge clk);

        // Back-to-back frames
        fork
            begin
                push_byte(8'hA3);
                chk("b2b_count1", 32'(fifo_count_o), 32'd1);
                push_byte(8'h0F);
                chk("b2b_count2", 32'(fifo_count_o), 32'd1);
                push_byte(8'hFF);
                chk("b2b_count3", 32'(fifo_count_o), 32'd2);
                valid_i = 1'b0;
            end
            begin
                check_frame(8'hA3, 4, 1'b0, 1'b0, 1'b0, 1'b1, 1);
                check_frame(8'h0F, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1);
                check_frame(8'hFF, 4, 1'b0, 1'b0, 1'b0, 1'b0, 0);
            end
        join
        @(negedge clk);
        chk("b2b_idle_busy", 32'(busy_o), 32'd0);
        repeat (3) @(negedge clk);

        // Parity and stop bits, div 5
        baud_div  = 16'd5;
        parity_en = 1'b1;
        push_byte(8'h07);
        valid_i = 1'b0;
        check_frame(8'h07, 5, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        repeat (3) @(negedge clk);
        parity_odd = 1'b1;
        push_byte(8'h07);
        valid_i = 1'b0;
        check_frame(8'h07, 5, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        repeat (3) @(negedge clk);
        two_stop = 1'b1;
        push_byte(8'h07);
        valid_i = 1'b0;
        check_frame(8'h07, 5, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        @(negedge clk);
        chk("two_stop_len_busy", 32'(busy_o), 32'd0);
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        two_stop   = 1'b0;
        repeat (3) @(negedge clk);

        // FIFO full with a slow line
        baud_div = 16'd100;
        for (int k = 0; k < 18; k++) fb[k] = 8'((k * 37 + 5) & 8'hFF);
        fork
            begin
                for (int k = 0; k < 17; k++) begin
                    push_byte(fb[k]);
                    chk($sformatf("full_count_%0d", k), 32'(fifo_count_o), (k == 0) ? 32'd1 : 32'(k));
                end
                chk("full_ready_low", 32'(ready_o), 32'd0);
                data_i = fb[17];
                repeat (20) @(negedge clk);
                chk("full_stall_count", 32'(fifo_count_o), 32'd16);
                n = 0;
                while (ready_o !== 1'b1 && n < 3000) begin
                    @(negedge clk);
                    n++;
                end
                chk("full_ready_return", 32'(ready_o), 32'd1);
                @(negedge clk);
                valid_i = 1'b0;
                chk("full_refill_count", 32'(fifo_count_o), 32'd16);
            end
            begin
                for (int k = 0; k < 18; k++)
                    check_frame(fb[k], 100, 1'b0, 1'b0, 1'b0, (k == 0), -1);
            end
        join
        @(negedge clk);
        chk("full_drained_busy", 32'(busy_o), 32'd0);
        repeat (3) @(negedge clk);

        // Divisor clamp, then reset during data bit 3 with 5 bytes queued
        baud_div = 16'd1;
        b0 = 8'h0A;
        push_byte(b0);
        for (int k = 1; k < 6; k++) push_byte(8'(8'h10 + k));
        valid_i = 1'b0;
        chk("clamp_queued", 32'(fifo_count_o), 32'd5);
        for (int c = 6; c <= 19; c++) begin
            int bi;
            logic e;
            if (c > 6) @(negedge clk);
            bi = (c - 2) / 4;
            e  = (bi == 0) ? 1'b0 : b0[bi-1];
            chk($sformatf("clamp_cycle_%0d", c), 32'(txd_o), 32'(e));
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_txd", 32'(txd_o), 32'd1);
        chk("rst_count", 32'(fifo_count_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd1);
        seen = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (txd_o !== 1'b1 || busy_o !== 1'b0) seen = 1'b1;
        end
        chk("rst_no_more_frames", 32'(seen), 32'd0);

        // Divisor change mid-frame takes effect on the next frame only
        baud_div = 16'd4;
        fork
            begin
                push_byte(8'h3C);
                push_byte(8'hC3);
                valid_i = 1'b0;
                repeat (15) @(negedge clk);
                baud_div = 16'd8;
            end
            begin
                check_frame(8'h3C, 4, 1'b0, 1'b0, 1'b0, 1'b1, -1);
                check_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1);
            end
        join
        @(negedge clk);
        chk("latch_idle_busy", 32'(busy_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
